// File: rtl/sdram_arbiter_if.sv
// Client/controller bundle for sdram_arbiter: CPU and DMA request ports plus the SDRAM controller slot bus.
// The arbiter uses the slave modport; clients and the controller model sit on the master side.
interface sdram_arbiter_if;
    logic        cpu_req;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_rnw;
    logic [1:0]  cpu_bsel;
    logic        cpu_ack;
    logic        cpu_rvalid;

    logic        dma_req;
    logic [23:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_rnw;
    logic [1:0]  dma_bsel;
    logic        dma_ack;
    logic        dma_rvalid;

    logic [15:0] rdata;

    logic        mem_cyc;
    logic        mem_req;
    logic        mem_rnw;
    logic [23:0] mem_a;
    logic [15:0] mem_di;
    logic [1:0]  mem_bsel;
    logic        mem_curr_cpu;
    logic [15:0] mem_do;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_rnw, cpu_bsel,
        input  dma_req, dma_addr, dma_wdata, dma_rnw, dma_bsel,
        input  mem_do,
        output cpu_ack, cpu_rvalid, dma_ack, dma_rvalid, rdata,
        output mem_cyc, mem_req, mem_rnw, mem_a, mem_di, mem_bsel, mem_curr_cpu
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_rnw, cpu_bsel,
        output dma_req, dma_addr, dma_wdata, dma_rnw, dma_bsel,
        output mem_do,
        input  cpu_ack, cpu_rvalid, dma_ack, dma_rvalid, rdata,
        input  mem_cyc, mem_req, mem_rnw, mem_a, mem_di, mem_bsel, mem_curr_cpu
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Slot scheduler in front of the SDRAM controller: one CPU/DMA grant per SLOT_LEN-clock slot, CPU first.
// Define SDRAM_ARB_DMA_GUARD_EN to let DMA win one slot after GUARD_MAX consecutive losses to the CPU.
module sdram_arbiter #(
    parameter int SLOT_LEN  = 8,
    parameter int GUARD_MAX = 3
) (
    input  logic           clk,
    input  logic           rst,
    sdram_arbiter_if.slave bus
);
    localparam int PH_W = $clog2(SLOT_LEN);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(SLOT_LEN - 1);
    localparam logic [PH_W-1:0] RET_PH  = PH_W'(1);

    if (SLOT_LEN < 8 || GUARD_MAX < 1) begin : g_paramCheck
        $error("sdram_arbiter: SLOT_LEN must be >= 8 and GUARD_MAX >= 1");
    end

    logic [PH_W-1:0] r_ph;
    logic            r_memCyc;
    logic            r_memReq;
    logic            r_memRnw;
    logic [23:0]     r_memA;
    logic [15:0]     r_memDi;
    logic [1:0]      r_memBsel;
    logic            r_memCurrCpu;
    logic            r_cpuAck;
    logic            r_dmaAck;
    logic            r_cpuRvalid;
    logic            r_dmaRvalid;
    logic [15:0]     r_rdata;
    logic            r_pendValid;
    logic            r_pendCpu;
    logic            r_retValid;
    logic            r_retCpu;

    logic            w_decide;
    logic            w_retEdge;
    logic            w_force;
    logic            w_cpuWin;
    logic            w_dmaWin;
    logic            w_winRnw;

    assign w_decide  = (r_ph == LAST_PH);
    assign w_retEdge = (r_ph == RET_PH);

`ifdef SDRAM_ARB_DMA_GUARD_EN
    localparam int GC_W = $clog2(GUARD_MAX + 1);
    localparam logic [GC_W-1:0] GUARD_LIM = GC_W'(GUARD_MAX);

    logic [GC_W-1:0] r_guard;

    assign w_force = bus.dma_req && (r_guard == GUARD_LIM);

    // Count only slots where DMA asked and lost; any DMA win or idle DMA clears the streak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_guard <= '0;
        end else if (w_decide) begin
            if (w_dmaWin || !bus.dma_req) begin
                r_guard <= '0;
            end else if (w_cpuWin && r_guard != GUARD_LIM) begin
                r_guard <= r_guard + GC_W'(1);
            end
        end
    end
`else
    assign w_force = 1'b0;
`endif

    assign w_cpuWin = bus.cpu_req && !w_force;
    assign w_dmaWin = bus.dma_req && !w_cpuWin;
    assign w_winRnw = w_cpuWin ? bus.cpu_rnw : bus.dma_rnw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph <= '0;
        end else begin
            r_ph <= (r_ph == LAST_PH) ? '0 : r_ph + PH_W'(1);
        end
    end

    // Slot decision: strobes last one clock, the access fields stay put for the whole slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memCyc     <= 1'b0;
            r_memReq     <= 1'b0;
            r_memRnw     <= 1'b0;
            r_memA       <= '0;
            r_memDi      <= '0;
            r_memBsel    <= '0;
            r_memCurrCpu <= 1'b0;
            r_cpuAck     <= 1'b0;
            r_dmaAck     <= 1'b0;
        end else begin
            r_memCyc <= w_decide;
            r_cpuAck <= w_decide && w_cpuWin;
            r_dmaAck <= w_decide && w_dmaWin;
            if (w_decide) begin
                r_memReq     <= w_cpuWin || w_dmaWin;
                r_memCurrCpu <= w_cpuWin;
                if (w_cpuWin) begin
                    r_memRnw  <= bus.cpu_rnw;
                    r_memA    <= bus.cpu_addr;
                    r_memDi   <= bus.cpu_wdata;
                    r_memBsel <= bus.cpu_bsel;
                end else if (w_dmaWin) begin
                    r_memRnw  <= bus.dma_rnw;
                    r_memA    <= bus.dma_addr;
                    r_memDi   <= bus.dma_wdata;
                    r_memBsel <= bus.dma_bsel;
                end
            end
        end
    end

    // Read data lands a slot after the access slot, so the owner is staged once (pend -> ret) before return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pendValid <= 1'b0;
            r_pendCpu   <= 1'b0;
            r_retValid  <= 1'b0;
            r_retCpu    <= 1'b0;
            r_rdata     <= '0;
            r_cpuRvalid <= 1'b0;
            r_dmaRvalid <= 1'b0;
        end else begin
            r_cpuRvalid <= w_retEdge && r_retValid && r_retCpu;
            r_dmaRvalid <= w_retEdge && r_retValid && !r_retCpu;
            if (w_decide) begin
                r_retValid  <= r_pendValid;
                r_retCpu    <= r_pendCpu;
                r_pendValid <= (w_cpuWin || w_dmaWin) && w_winRnw;
                r_pendCpu   <= w_cpuWin;
            end else if (w_retEdge && r_retValid) begin
                r_rdata    <= bus.mem_do;
                r_retValid <= 1'b0;
            end
        end
    end

    assign bus.mem_cyc      = r_memCyc;
    assign bus.mem_req      = r_memReq;
    assign bus.mem_rnw      = r_memRnw;
    assign bus.mem_a        = r_memA;
    assign bus.mem_di       = r_memDi;
    assign bus.mem_bsel     = r_memBsel;
    assign bus.mem_curr_cpu = r_memCurrCpu;
    assign bus.cpu_ack      = r_cpuAck;
    assign bus.dma_ack      = r_dmaAck;
    assign bus.cpu_rvalid   = r_cpuRvalid;
    assign bus.dma_rvalid   = r_dmaRvalid;
    assign bus.rdata        = r_rdata;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: per-slot grant vectors from a table plus hand-written read-latency,
// contention and mid-slot reset sequences.
module tb_sdram_arbiter;
    localparam int SLOT_LEN = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    sdram_arbiter_if bus();

    sdram_arbiter #(.SLOT_LEN(SLOT_LEN), .GUARD_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        cpuReq;
        logic [23:0] cpuAddr;
        logic [15:0] cpuWdata;
        logic        cpuRnw;
        logic [1:0]  cpuBsel;
        logic        dmaReq;
        logic [23:0] dmaAddr;
        logic [15:0] dmaWdata;
        logic        dmaRnw;
        logic [1:0]  dmaBsel;
        logic        expCpuAck;
        logic        expDmaAck;
        logic        expReq;
        logic        expRnw;
        logic [23:0] expA;
        logic [15:0] expDi;
        logic [1:0]  expBsel;
        logic        expCurrCpu;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input string n,
                                input logic cr, input logic [23:0] ca, input logic [15:0] cw,
                                input logic crnw, input logic [1:0] cb,
                                input logic dr, input logic [23:0] da, input logic [15:0] dw,
                                input logic drnw, input logic [1:0] db,
                                input logic eca, input logic eda, input logic ereq, input logic ernw,
                                input logic [23:0] ea, input logic [15:0] edi, input logic [1:0] eb,
                                input logic ecur);
        vec_t v;
        v.name = n;
        v.cpuReq = cr;  v.cpuAddr = ca; v.cpuWdata = cw; v.cpuRnw = crnw; v.cpuBsel = cb;
        v.dmaReq = dr;  v.dmaAddr = da; v.dmaWdata = dw; v.dmaRnw = drnw; v.dmaBsel = db;
        v.expCpuAck = eca; v.expDmaAck = eda; v.expReq = ereq; v.expRnw = ernw;
        v.expA = ea; v.expDi = edi; v.expBsel = eb; v.expCurrCpu = ecur;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.cpu_req   = v.cpuReq;
        bus.cpu_addr  = v.cpuAddr;
        bus.cpu_wdata = v.cpuWdata;
        bus.cpu_rnw   = v.cpuRnw;
        bus.cpu_bsel  = v.cpuBsel;
        bus.dma_req   = v.dmaReq;
        bus.dma_addr  = v.dmaAddr;
        bus.dma_wdata = v.dmaWdata;
        bus.dma_rnw   = v.dmaRnw;
        bus.dma_bsel  = v.dmaBsel;
    endtask

    task automatic clearReqs();
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
    endtask

    task automatic waitCyc(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * SLOT_LEN && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_cyc === 1'b1) seen = 1'b1;
        end
        checkOutput({name, "_cycSeen"}, 32'(seen), 32'd1);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_cyc"},    32'(bus.mem_cyc),      32'd0);
        checkOutput({name, "_req"},    32'(bus.mem_req),      32'd0);
        checkOutput({name, "_rnw"},    32'(bus.mem_rnw),      32'd0);
        checkOutput({name, "_a"},      32'(bus.mem_a),        32'd0);
        checkOutput({name, "_di"},     32'(bus.mem_di),       32'd0);
        checkOutput({name, "_bsel"},   32'(bus.mem_bsel),     32'd0);
        checkOutput({name, "_curr"},   32'(bus.mem_curr_cpu), 32'd0);
        checkOutput({name, "_acks"},   32'({bus.cpu_ack, bus.dma_ack}),       32'd0);
        checkOutput({name, "_rvalid"}, 32'({bus.cpu_rvalid, bus.dma_rvalid}), 32'd0);
        checkOutput({name, "_rdata"},  32'(bus.rdata),        32'd0);
    endtask

    // Grants a single read and checks the owner's rvalid arrives exactly SLOT_LEN+2 clocks after the ack.
    task automatic readSequence(input string name, input logic isCpu, input logic [23:0] addr,
                                input logic [15:0] data);
        vec_t v;
        if (isCpu) v = mk(name, 1'b1, addr, 16'h0, 1'b1, 2'b11, 1'b0, 24'h0, 16'h0, 1'b0, 2'b00,
                          1'b1, 1'b0, 1'b1, 1'b1, addr, 16'h0, 2'b11, 1'b1);
        else       v = mk(name, 1'b0, 24'h0, 16'h0, 1'b0, 2'b00, 1'b1, addr, 16'h0, 1'b1, 2'b11,
                          1'b0, 1'b1, 1'b1, 1'b1, addr, 16'h0, 2'b11, 1'b0);
        applyStimulus(v);
        waitCyc(name);
        checkOutput({name, "_cpuAck"}, 32'(bus.cpu_ack),      32'(isCpu));
        checkOutput({name, "_dmaAck"}, 32'(bus.dma_ack),      32'(!isCpu));
        checkOutput({name, "_a"},      32'(bus.mem_a),        32'(addr));
        checkOutput({name, "_rnw"},    32'(bus.mem_rnw),      32'd1);
        checkOutput({name, "_curr"},   32'(bus.mem_curr_cpu), 32'(isCpu));
        clearReqs();
        bus.mem_do = data;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkOutput({name, "_cpuRvalid"}, 32'(bus.cpu_rvalid), 32'(isCpu && k == 10));
            checkOutput({name, "_dmaRvalid"}, 32'(bus.dma_rvalid), 32'(!isCpu && k == 10));
            if (k == 10) checkOutput({name, "_rdata"}, 32'(bus.rdata), 32'(data));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = mk("dmaWr",  1'b0, 24'h0, 16'h0, 1'b0, 2'b00,
                     1'b1, 24'h000100, 16'h55AA, 1'b0, 2'b01,
                     1'b0, 1'b1, 1'b1, 1'b0, 24'h000100, 16'h55AA, 2'b01, 1'b0);
        vecs[1] = mk("cpuWr",  1'b1, 24'hABCDEF, 16'h1234, 1'b0, 2'b11,
                     1'b0, 24'h0, 16'h0, 1'b0, 2'b00,
                     1'b1, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 16'h1234, 2'b11, 1'b1);
        vecs[2] = mk("idleA",  1'b0, 24'h0, 16'h0, 1'b0, 2'b00,
                     1'b0, 24'h0, 16'h0, 1'b0, 2'b00,
                     1'b0, 1'b0, 1'b0, 1'b0, 24'hABCDEF, 16'h1234, 2'b11, 1'b0);
        vecs[3] = mk("dmaRd",  1'b0, 24'h0, 16'h0, 1'b0, 2'b00,
                     1'b1, 24'h7FFFFF, 16'hAAAA, 1'b1, 2'b10,
                     1'b0, 1'b1, 1'b1, 1'b1, 24'h7FFFFF, 16'hAAAA, 2'b10, 1'b0);
        vecs[4] = mk("both",   1'b1, 24'h000001, 16'h0F0F, 1'b0, 2'b01,
                     1'b1, 24'h222222, 16'h3333, 1'b1, 2'b11,
                     1'b1, 1'b0, 1'b1, 1'b0, 24'h000001, 16'h0F0F, 2'b01, 1'b1);
        vecs[5] = mk("idleB",  1'b0, 24'h0, 16'h0, 1'b1, 2'b00,
                     1'b0, 24'h0, 16'h0, 1'b1, 2'b00,
                     1'b0, 1'b0, 1'b0, 1'b0, 24'h000001, 16'h0F0F, 2'b01, 1'b0);
        vecs[6] = mk("cpuRd",  1'b1, 24'hFFFFFF, 16'hC0DE, 1'b1, 2'b11,
                     1'b0, 24'h0, 16'h0, 1'b0, 2'b00,
                     1'b1, 1'b0, 1'b1, 1'b1, 24'hFFFFFF, 16'hC0DE, 2'b11, 1'b1);
        vecs[7] = mk("dmaWr0", 1'b0, 24'h0, 16'h0, 1'b0, 2'b00,
                     1'b1, 24'h000000, 16'hFFFF, 1'b0, 2'b00,
                     1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 16'hFFFF, 2'b00, 1'b0);

        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_rnw = 1'b0; bus.cpu_bsel = '0;
        bus.dma_req = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_rnw = 1'b0; bus.dma_bsel = '0;
        bus.mem_do  = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            checkOutput("idleCyc",   32'(bus.mem_cyc), 32'(k % SLOT_LEN == 0));
            checkOutput("idleReq",   32'(bus.mem_req), 32'd0);
            checkOutput("idleAcks",  32'({bus.cpu_ack, bus.dma_ack, bus.cpu_rvalid, bus.dma_rvalid}), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            waitCyc(vecs[i].name);
            checkOutput({vecs[i].name, "_cpuAck"}, 32'(bus.cpu_ack),      32'(vecs[i].expCpuAck));
            checkOutput({vecs[i].name, "_dmaAck"}, 32'(bus.dma_ack),      32'(vecs[i].expDmaAck));
            checkOutput({vecs[i].name, "_req"},    32'(bus.mem_req),      32'(vecs[i].expReq));
            checkOutput({vecs[i].name, "_rnw"},    32'(bus.mem_rnw),      32'(vecs[i].expRnw));
            checkOutput({vecs[i].name, "_a"},      32'(bus.mem_a),        32'(vecs[i].expA));
            checkOutput({vecs[i].name, "_di"},     32'(bus.mem_di),       32'(vecs[i].expDi));
            checkOutput({vecs[i].name, "_bsel"},   32'(bus.mem_bsel),     32'(vecs[i].expBsel));
            checkOutput({vecs[i].name, "_curr"},   32'(bus.mem_curr_cpu), 32'(vecs[i].expCurrCpu));
            clearReqs();
            @(negedge clk);
            checkOutput({vecs[i].name, "_cycDrop"}, 32'(bus.mem_cyc), 32'd0);
            checkOutput({vecs[i].name, "_ackDrop"}, 32'({bus.cpu_ack, bus.dma_ack}), 32'd0);
            checkOutput({vecs[i].name, "_reqHold"}, 32'(bus.mem_req), 32'(vecs[i].expReq));
            checkOutput({vecs[i].name, "_aHold"},   32'(bus.mem_a),   32'(vecs[i].expA));
        end

        readSequence("cpuRead", 1'b1, 24'h012345, 16'hBEEF);
        readSequence("dmaRead", 1'b0, 24'h0000F0, 16'h1357);

        // Both clients hold their request across ten slots.
        applyStimulus(mk("contend", 1'b1, 24'h100000, 16'h0, 1'b1, 2'b11,
                         1'b1, 24'h200000, 16'h0, 1'b1, 2'b11,
                         1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 1'b0));
        for (int s = 0; s < 10; s++) begin
            logic expCpu;
`ifdef SDRAM_ARB_DMA_GUARD_EN
            expCpu = (s % 4) != 3;
`else
            expCpu = 1'b1;
`endif
            waitCyc("contend");
            checkOutput("contendCpuAck", 32'(bus.cpu_ack),      32'(expCpu));
            checkOutput("contendDmaAck", 32'(bus.dma_ack),      32'(!expCpu));
            checkOutput("contendCurr",   32'(bus.mem_curr_cpu), 32'(expCpu));
            checkOutput("contendA",      32'(bus.mem_a),        expCpu ? 32'h100000 : 32'h200000);
        end
        clearReqs();

        // Reset lands in ph==4 of a CPU read slot; the pending return must vanish.
        applyStimulus(mk("midRst", 1'b1, 24'h0ABCDE, 16'h0, 1'b1, 2'b11,
                         1'b0, 24'h0, 16'h0, 1'b0, 2'b00,
                         1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 1'b0));
        waitCyc("midRst");
        checkOutput("midRstAck", 32'(bus.cpu_ack), 32'd1);
        clearReqs();
        bus.mem_do = 16'h4444;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkAllZero("midRst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkOutput("postRstRvalid", 32'(bus.cpu_rvalid), 32'd0);
            checkOutput("postRstAck",    32'(bus.cpu_ack),    32'd0);
            checkOutput("postRstCyc",    32'(bus.mem_cyc),    32'(k == SLOT_LEN));
            checkOutput("postRstRdata",  32'(bus.rdata),      32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
